// File: rtl/display_driver_bcm.sv
// display_driver_bcm: HUB75 panel driver using binary code modulation.
// Planes are shown LSB first; the next plane is shifted while the current
// one is lit. Define DISPLAY_DRIVER_BRIGHTNESS_EN to add a global brightness
// input that shortens the oe-high time of every plane.
module display_driver_bcm #(
    parameter int segments    = 1,
    parameter int rows        = 8,
    parameter int columns     = 32,
    parameter int bitwidth    = 8,
    parameter int base_cycles = 1
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef DISPLAY_DRIVER_BRIGHTNESS_EN
    input  logic [7:0]                 brightness,
`endif
    output logic                       frame_complete,
    output logic [$clog2(rows)-1:0]    row,
    output logic [$clog2(columns)-1:0] column,
    input  logic [24*segments-1:0]     pixel,
    output logic [$clog2(rows)-1:0]    panel_row,
    output logic [3*segments-1:0]      rgb,
    output logic                       oe,
    output logic                       lat,
    output logic                       oclk
);

    localparam int RW        = $clog2(rows);
    localparam int CW        = $clog2(columns);
    localparam int PW        = (bitwidth > 1) ? $clog2(bitwidth) : 1;
    localparam int RGB_W     = 3 * segments;
    localparam int SHIFT_LEN = 2 * columns + 1;
    localparam int MAX_DISP  = base_cycles << (bitwidth - 1);
    localparam int CNT_MAX   = (MAX_DISP > SHIFT_LEN) ? MAX_DISP : SHIFT_LEN;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [2:0] BIT_OFS = 3'(8 - bitwidth);

    typedef enum logic [1:0] {FILL, LATCH, DISPLAY} state_t;

    state_t           state, nxt_state;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic [PW-1:0]    sh_plane, disp_plane;
    logic [CNT_W-1:0] disp_len, slot_last, on_time;
    logic             cur_shift, nxt_shift;
`ifdef DISPLAY_DRIVER_BRIGHTNESS_EN
    logic [7:0]       br_q;
`endif

    // Display length of plane p before any brightness scaling.
    function automatic logic [CNT_W-1:0] plane_cycles(input logic [PW-1:0] p);
        return CNT_W'(base_cycles) << p;
    endfunction

`ifdef DISPLAY_DRIVER_BRIGHTNESS_EN
    // (d * (br + 1)) >> 8; never exceeds d, so truncation to CNT_W is safe.
    function automatic logic [CNT_W-1:0] scale_on(input logic [CNT_W-1:0] d,
                                                  input logic [7:0] br);
        logic [CNT_W+8:0] prod;
        prod = (CNT_W+9)'(d) * (CNT_W+9)'({1'b0, br} + 9'd1);
        return CNT_W'(prod >> 8);
    endfunction
`endif

    // Pick the plane bit of every channel of every segment.
    function automatic logic [RGB_W-1:0] plane_bits(input logic [24*segments-1:0] px,
                                                    input logic [PW-1:0] p);
        logic [23:0]      seg;
        logic [2:0]       idx;
        logic [RGB_W-1:0] res;
        idx = BIT_OFS + 3'(p);
        res = '0;
        for (int s = 0; s < segments; s++) begin
            seg = 24'(px >> (24 * s));
            res = res | (RGB_W'({seg[16 + idx], seg[8 + idx], seg[idx]}) << (3 * s));
        end
        return res;
    endfunction

    // Slot timing of the displayed plane and sequencer next state.
    always_comb begin
        disp_len  = plane_cycles(disp_plane);
        slot_last = ((disp_len > CNT_W'(SHIFT_LEN)) ? disp_len : CNT_W'(SHIFT_LEN)) - CNT_W'(1);
`ifdef DISPLAY_DRIVER_BRIGHTNESS_EN
        // The brightness sampled in the frame_complete cycle already governs the
        // first slot of the new frame.
        on_time   = scale_on(disp_len, frame_complete ? brightness : br_q);
`else
        on_time   = disp_len;
`endif
        nxt_state = state;
        nxt_cnt   = cnt + CNT_W'(1);
        case (state)
            FILL: begin
                if (cnt == CNT_W'(SHIFT_LEN - 1)) begin
                    nxt_state = LATCH;
                    nxt_cnt   = '0;
                end
            end
            LATCH: begin
                nxt_state = DISPLAY;
                nxt_cnt   = '0;
            end
            DISPLAY: begin
                if (cnt == slot_last) begin
                    nxt_state = LATCH;
                    nxt_cnt   = '0;
                end
            end
            default: begin
                nxt_state = FILL;
                nxt_cnt   = '0;
            end
        endcase
        cur_shift = (state == FILL) || (state == DISPLAY && cnt <= CNT_W'(2 * columns));
        nxt_shift = (nxt_state == FILL) ||
                    (nxt_state == DISPLAY && nxt_cnt <= CNT_W'(2 * columns));
    end

    // Sequencer state, shift slot bookkeeping and registered panel outputs.
    // The read column leads the shift index by one cycle so the returned pixel
    // can be registered onto rgb one cycle before the matching oclk rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= FILL;
            cnt            <= '0;
            sh_plane       <= '0;
            disp_plane     <= '0;
            row            <= '0;
            column         <= '0;
            panel_row      <= '0;
            rgb            <= '0;
            oe             <= 1'b0;
            lat            <= 1'b0;
            oclk           <= 1'b0;
            frame_complete <= 1'b0;
`ifdef DISPLAY_DRIVER_BRIGHTNESS_EN
            br_q           <= brightness;
`endif
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
            lat   <= (nxt_state == LATCH);
            oe    <= (nxt_state == DISPLAY) && (nxt_cnt < on_time);
            oclk  <= nxt_shift && !nxt_cnt[0] && (nxt_cnt != '0);
            frame_complete <= (state == DISPLAY) && (nxt_state == LATCH) &&
                              (panel_row == RW'(rows - 1)) &&
                              (disp_plane == PW'(bitwidth - 1));
`ifdef DISPLAY_DRIVER_BRIGHTNESS_EN
            if (frame_complete)
                br_q <= brightness;
`endif
            if (nxt_shift && nxt_cnt[0])
                column <= (column == CW'(columns - 1)) ? '0 : column + CW'(1);
            if (cur_shift && !cnt[0] && cnt != CNT_W'(2 * columns))
                rgb <= plane_bits(pixel, sh_plane);
            // Entering LATCH: show the just-shifted plane, point reads at the next one.
            if (nxt_state == LATCH && state != LATCH) begin
                panel_row  <= row;
                disp_plane <= sh_plane;
                if (sh_plane == PW'(bitwidth - 1)) begin
                    sh_plane <= '0;
                    row      <= (row == RW'(rows - 1)) ? '0 : row + RW'(1);
                end else begin
                    sh_plane <= sh_plane + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_display_driver_bcm.sv
// Directed testbench for display_driver_bcm (default parameters plus a
// two-segment instance). Brightness scenario is built when
// DISPLAY_DRIVER_BRIGHTNESS_EN is defined.
module tb_display_driver_bcm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [23:0] pixel;
    logic [47:0] pixel2;
    logic        frame_complete, oe, lat, oclk;
    logic [2:0]  row, panel_row, rgb;
    logic [4:0]  column;
    logic        frame_complete2, oe2, lat2, oclk2;
    logic [2:0]  row2, panel_row2;
    logic [4:0]  column2;
    logic [5:0]  rgb2;
`ifdef DISPLAY_DRIVER_BRIGHTNESS_EN
    logic [7:0]  brightness;
    int          chg_at;
    logic [7:0]  chg_val;
`endif

    int checks = 0;
    int errors = 0;

    int frame_len, oe_p0, lat_oe, pr_bad, sel_bad, slot, slot2;
    int seg_bad, seg_edges, addr2_bad, pr2_bad, oe2_total, fc2_cnt, e2;
    int oe_row[8];
    int ones_row[8];
    logic oclk_prev  = 1'b0;
    logic oclk2_prev = 1'b0;
    logic [2:0] pr_prev;

    display_driver_bcm dut (
        .clk            (clk),
        .rst            (rst),
`ifdef DISPLAY_DRIVER_BRIGHTNESS_EN
        .brightness     (brightness),
`endif
        .frame_complete (frame_complete),
        .row            (row),
        .column         (column),
        .pixel          (pixel),
        .panel_row      (panel_row),
        .rgb            (rgb),
        .oe             (oe),
        .lat            (lat),
        .oclk           (oclk)
    );

    display_driver_bcm #(.segments(2)) dut2 (
        .clk            (clk),
        .rst            (rst),
`ifdef DISPLAY_DRIVER_BRIGHTNESS_EN
        .brightness     (brightness),
`endif
        .frame_complete (frame_complete2),
        .row            (row2),
        .column         (column2),
        .pixel          (pixel2),
        .panel_row      (panel_row2),
        .rgb            (rgb2),
        .oe             (oe2),
        .lat            (lat2),
        .oclk           (oclk2)
    );

    // Advance to the next frame_complete cycle (at least one cycle), bounded.
    task automatic wait_fc(output bit ok);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_complete !== 1'b1 && n < 12000);
        ok = (frame_complete === 1'b1);
    endtask

    // Observe one frame starting at a frame_complete cycle, gathering statistics.
    task automatic run_frame();
        int n;
        n = 0; oe_p0 = 0; lat_oe = 0; pr_bad = 0; sel_bad = 0;
        seg_bad = 0; seg_edges = 0; addr2_bad = 0; pr2_bad = 0;
        oe2_total = 0; fc2_cnt = 0; e2 = 0;
        slot = -1; slot2 = -1;
        for (int r = 0; r < 8; r++) begin
            oe_row[r] = 0;
            ones_row[r] = 0;
        end
        pr_prev = panel_row;
        do begin
            if (lat) slot++;
            if (lat2) begin
                slot2++;
                e2 = 0;
                if (panel_row2 !== 3'(slot2 / 8)) pr2_bad++;
            end
            if (oe) begin
                oe_row[panel_row]++;
                if (slot % 8 == 0) oe_p0++;
            end
            if (lat && oe) lat_oe++;
            if (panel_row !== pr_prev && !lat) pr_bad++;
            pr_prev = panel_row;
            if (oclk && !oclk_prev) begin
                if (rgb[2]) ones_row[row]++;
                if (rgb[2] !== (((slot + 1) % 8) == 7) || rgb[1:0] !== 2'b00) sel_bad++;
            end
            if (oclk2 && !oclk2_prev) begin
                seg_edges++;
                e2++;
                if (rgb2 !== 6'b001100) seg_bad++;
                if (row2 !== 3'(((slot2 + 1) / 8) % 8) || column2 !== 5'(e2 % 32)) addr2_bad++;
            end
            if (oe2) oe2_total++;
            if (frame_complete2) fc2_cnt++;
            oclk_prev  = oclk;
            oclk2_prev = oclk2;
`ifdef DISPLAY_DRIVER_BRIGHTNESS_EN
            if (n == chg_at) brightness = chg_val;
`endif
            @(negedge clk);
            n++;
        end while (frame_complete !== 1'b1 && n < 20000);
        frame_len = n;
    endtask

    task automatic test_reset();
        int edges, col_bad, lat_at;
        logic prev;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({frame_complete, row, column, panel_row, rgb, oe, lat, oclk} !== 18'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got %b, expected all zero", i,
                         {frame_complete, row, column, panel_row, rgb, oe, lat, oclk});
            end
        end
        rst = 1'b0;
        edges = 0; col_bad = 0; lat_at = -1; prev = oclk;
        for (int n = 1; n <= 200 && lat_at < 0; n++) begin
            @(negedge clk);
            if (oclk && !prev) begin
                edges++;
                if (column !== 5'(edges % 32)) col_bad++;
            end
            prev = oclk;
            if (lat === 1'b1) lat_at = n;
        end
        checks++;
        if (lat_at !== 65) begin
            errors++;
            $display("FAIL fill_first_lat: got cycle %0d, expected 65", lat_at);
        end
        checks++;
        if (edges !== 32) begin
            errors++;
            $display("FAIL fill_oclk_edges: got %0d, expected 32", edges);
        end
        checks++;
        if (col_bad !== 0) begin
            errors++;
            $display("FAIL fill_columns: %0d wrong column values, expected 0", col_bad);
        end
        checks++;
        if (panel_row !== 3'd0 || oe !== 1'b0) begin
            errors++;
            $display("FAIL fill_latch_state: panel_row=%0d oe=%b, expected 0 0", panel_row, oe);
        end
    endtask

    task automatic test_full_white();
        bit ok;
        pixel = 24'hffffff;
        wait_fc(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL white_wait_fc: frame_complete not seen, expected within bound");
        end
        run_frame();
        checks++;
        if (frame_len !== 4728) begin
            errors++;
            $display("FAIL white_frame_len: got %0d, expected 4728", frame_len);
        end
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (oe_row[r] !== 255) begin
                errors++;
                $display("FAIL white_oe_row%0d: got %0d, expected 255", r, oe_row[r]);
            end
        end
        checks++;
        if (lat_oe !== 0) begin
            errors++;
            $display("FAIL white_lat_oe_overlap: got %0d cycles, expected 0", lat_oe);
        end
        checks++;
        if (pr_bad !== 0) begin
            errors++;
            $display("FAIL white_panel_row_outside_latch: got %0d, expected 0", pr_bad);
        end
    endtask

    task automatic test_plane_select();
        pixel = 24'h800000;
        run_frame();
        checks++;
        if (sel_bad !== 0) begin
            errors++;
            $display("FAIL plane_select_bits: %0d bad oclk samples, expected 0", sel_bad);
        end
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (ones_row[r] !== 32) begin
                errors++;
                $display("FAIL plane_select_ones_row%0d: got %0d, expected 32", r, ones_row[r]);
            end
        end
    endtask

    task automatic test_segments();
        pixel2 = {24'h0000ff, 24'hff0000};
        run_frame();
        checks++;
        if (seg_edges !== 2048) begin
            errors++;
            $display("FAIL seg_oclk_edges: got %0d, expected 2048", seg_edges);
        end
        checks++;
        if (seg_bad !== 0) begin
            errors++;
            $display("FAIL seg_rgb: %0d edges not 001100, expected 0", seg_bad);
        end
        checks++;
        if (addr2_bad !== 0 || pr2_bad !== 0) begin
            errors++;
            $display("FAIL seg_addressing: addr %0d panel_row %0d bad, expected 0 0", addr2_bad, pr2_bad);
        end
        checks++;
        if (oe2_total !== 2040 || fc2_cnt !== 1) begin
            errors++;
            $display("FAIL seg_timing: oe %0d fc %0d, expected 2040 1", oe2_total, fc2_cnt);
        end
    endtask

`ifdef DISPLAY_DRIVER_BRIGHTNESS_EN
    task automatic test_brightness();
        pixel = 24'hffffff;
        chg_at = 50;
        chg_val = 8'd127;
        run_frame();
        chg_at = -1;
        checks++;
        if (frame_len !== 4728) begin
            errors++;
            $display("FAIL bright_change_frame_len: got %0d, expected 4728", frame_len);
        end
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (oe_row[r] !== 255) begin
                errors++;
                $display("FAIL bright_midframe_row%0d: got %0d, expected 255", r, oe_row[r]);
            end
        end
        run_frame();
        checks++;
        if (frame_len !== 4728) begin
            errors++;
            $display("FAIL bright_frame_len: got %0d, expected 4728", frame_len);
        end
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (oe_row[r] !== 127) begin
                errors++;
                $display("FAIL bright_oe_row%0d: got %0d, expected 127", r, oe_row[r]);
            end
        end
        checks++;
        if (oe_p0 !== 0) begin
            errors++;
            $display("FAIL bright_plane0_oe: got %0d, expected 0", oe_p0);
        end
        brightness = 8'd255;
    endtask
`endif

    task automatic test_reset_mid();
        int n, lat_at;
        n = 0;
        while (!(panel_row === 3'd3 && oe === 1'b1) && n < 10000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(panel_row === 3'd3 && oe === 1'b1)) begin
            errors++;
            $display("FAIL rstmid_find_row3: panel_row=%0d oe=%b, expected 3 1", panel_row, oe);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (oe !== 1'b0 || lat !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_oe_lat: oe=%b lat=%b, expected 0 0", oe, lat);
        end
        checks++;
        if (panel_row !== 3'd0 || row !== 3'd0) begin
            errors++;
            $display("FAIL rstmid_rows: panel_row=%0d row=%0d, expected 0 0", panel_row, row);
        end
        checks++;
        if (oclk !== 1'b0 || frame_complete !== 1'b0 || column !== 5'd0) begin
            errors++;
            $display("FAIL rstmid_misc: oclk=%b fc=%b column=%0d, expected 0 0 0",
                     oclk, frame_complete, column);
        end
        lat_at = -1;
        for (int k = 1; k <= 200 && lat_at < 0; k++) begin
            @(negedge clk);
            if (lat === 1'b1) lat_at = k;
        end
        checks++;
        if (lat_at !== 65) begin
            errors++;
            $display("FAIL rstmid_first_lat: got cycle %0d, expected 65", lat_at);
        end
    endtask

    initial begin
        rst    = 1'b1;
        pixel  = 24'h000000;
        pixel2 = {24'h0000ff, 24'hff0000};
`ifdef DISPLAY_DRIVER_BRIGHTNESS_EN
        brightness = 8'd255;
        chg_at     = -1;
        chg_val    = 8'd255;
`endif
        test_reset();
        test_full_white();
        test_plane_select();
        test_segments();
`ifdef DISPLAY_DRIVER_BRIGHTNESS_EN
        test_brightness();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
